fir_deconv: RTL
===============

# fir_deconv

Inverse (deconvolution) stage for the team's 3-tap FIR y[n] = 3·x[n] + 2·x[n-1] + 1·x[n-2]. Accepts filtered samples y and recovers the original samples x[n] = (y[n] − 2·x[n-1] − x[n-2]) / 3. The divide by 3 is done in a multi-cycle restoring divider, and input and output use valid/ready handshakes. The block sits at the receive end of a link whose transmit end is the FIR filter, and flags any sample that is inconsistent with an FIR-generated stream.

## Interface
- X_W, 8, width of recovered sample x (unsigned)
- Y_W, 16, width of filtered sample y (unsigned)
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-high
- y_in  in  Y_W  filtered sample
- y_valid  in  1  y_in valid
- y_ready  out  1  block can accept y_in
- x_out  out  X_W  recovered sample
- x_valid  out  1  x_out valid
- x_ready  in  1  downstream accepts x_out
- err  out  1  sticky error flag (inexact, negative or saturated sample seen)
- err_clr  in  1  clears err

## Operation
- States:
  - IDLE: y_ready=1.
  - DIV: 16 cycles, y_ready=0.
  - OUT: x_valid=1.
- History registers x1 = x[n-1] and x2 = x[n-2], both X_W bits. Both are 0 after reset.
- Acceptance (IDLE, y_valid=1 at edge):
  - Compute the signed (Y_W+2)-bit value num = y_in − 2·x1 − x2.
  - If num < 0: load 0 into the dividend and set a per-sample neg flag.
  - Otherwise: load num[Y_W-1:0] into the dividend.
  - Clear the bit counter. Go to DIV.
- DIV:
  - Restoring division by 3, one quotient bit per cycle, MSB first.
  - The partial remainder is 2 bits wide, with a 3-bit trial subtract.
  - After bit 0 is produced, go to OUT.
- Result rules, applied on entry to OUT:
  - If neg: x_out=0 and err is set.
  - Else if quotient > 2^X_W − 1: x_out=255 (saturated) and err is set.
  - Else: x_out = quotient[X_W-1:0]. If the remainder ≠ 0, err is set.
  - History update: x2←x1, x1←x_out, using the emitted (possibly clamped) value.
- OUT:
  - Hold x_out and x_valid until x_valid && x_ready at an edge, then go to IDLE.
  - x_out is stable and unchanged while x_ready=0.
- err:
  - Cleared only by reset or by err_clr.
  - If err_clr and a new error condition occur in the same cycle, set wins.
- Reset in any state, including mid-DIV or OUT: the in-flight sample is discarded, history is cleared, and the block returns to IDLE next cycle.

## Timing
- Reset values: y_ready=1 (state IDLE), x_valid=0, x_out=0, err=0.
- Latency: sample accepted at edge k → x_valid high after edge k+16.
- Initiation interval: ≥18 cycles per sample (1 IDLE + 16 DIV + ≥1 OUT).
- y_ready is 0 outside IDLE. No combinational path from y_valid to y_ready, or from x_ready to x_valid.

## Structure
- Package fir_pkg holds:
  - coefficient constants C0=3, C1=2, C2=1;
  - default widths X_W and Y_W;
  - state enum {IDLE, DIV, OUT}.
- The FIR filter reuses fir_pkg.
- Sub-module seq_div3:
  - Inputs: start, dividend[Y_W-1:0].
  - Outputs: done pulse, quotient[Y_W-1:0], rem[1:0].
  - Contains the bit counter and the remainder register.
- Top level: handshake FSM, history registers, numerator arithmetic, saturation and err.

## Test plan
- Impulse: y = 30,20,10,0,0 from reset → x_out = 10,0,0,0,0, err=0. First x_valid appears 16 cycles after the first acceptance edge.
- Round trip: drive x = 0..255 ramp plus random values through the FIR and feed its y to this block. x_out must equal x exactly, with err=0 throughout.
- Inexact and negative inputs:
  - y=31 from reset → x_out=10, err=1.
  - After err_clr, then x history {10,0} and y=0 → num=−20 → x_out=0, err=1.
- Saturation: y=1000 from reset → quotient 333 → x_out=255, err=1. Next y=765 gives num = 765−510−0 = 255 → x_out=85.
- Backpressure: hold x_ready=0 for 10 cycles in OUT → x_out and x_valid stay stable and y_ready stays 0. Release → exactly one transfer, then y_ready=1.
- Reset mid-DIV: assert reset at DIV cycle 7 → next cycle IDLE, x_valid=0, history cleared. Then y=30 → x_out=10.

Source files
------------

// File: rtl/fir_pkg.sv
// fir_pkg: shared constants and types for the 3-tap FIR link
// y[n] = C0*x[n] + C1*x[n-1] + C2*x[n-2] and its inverse (fir_deconv).
// Contents: coefficient constants, default sample widths, FSM state enum.
package fir_pkg;

  // Default widths: recovered sample x and filtered sample y (both unsigned).
  localparam int X_W = 8;
  localparam int Y_W = 16;

  // FIR coefficients. C0 is also the divisor used by the inverse stage.
  localparam logic [1:0] C0 = 2'd3;
  localparam logic [1:0] C1 = 2'd2;
  localparam logic [1:0] C2 = 2'd1;

  // Handshake FSM states of the inverse stage.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/fir_deconv_if.sv
// fir_deconv_if: groups the two valid/ready streams of fir_deconv.
//   y side: y_in / y_valid from the producer, y_ready back to the producer.
//   x side: x_out / x_valid to the consumer, x_ready back from the consumer.
// Modports:
//   master - the environment: drives y_in/y_valid/x_ready.
//   slave  - the fir_deconv block: drives y_ready/x_out/x_valid.
interface fir_deconv_if;

  logic [fir_pkg::Y_W-1:0] y_in;
  logic                    y_valid;
  logic                    y_ready;
  logic [fir_pkg::X_W-1:0] x_out;
  logic                    x_valid;
  logic                    x_ready;

  modport master (
    output y_in,
    output y_valid,
    input  y_ready,
    input  x_out,
    input  x_valid,
    output x_ready
  );

  modport slave (
    input  y_in,
    input  y_valid,
    output y_ready,
    output x_out,
    output x_valid,
    input  x_ready
  );

endinterface

// File: rtl/fir_deconv_seq_div3.sv
// seq_div3: sequential restoring divider by C0 (=3), one quotient bit per
// cycle, MSB first, Y_W cycles per division.
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   start      - load dividend and begin a division
//   dividend   - unsigned Y_W-bit dividend (sampled when start=1)
//   done       - high during the cycle whose edge produces quotient bit 0
//   quotient   - final quotient, valid while done=1
//   rem        - final remainder (0..2), valid while done=1
module seq_div3
  import fir_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [Y_W-1:0] dividend,
  output logic           done,
  output logic [Y_W-1:0] quotient,
  output logic [1:0]     rem
);

  localparam int              CNT_W    = $clog2(Y_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Y_W - 1);

  logic             r_busy;
  logic [CNT_W-1:0] r_cnt;
  // Dividend bits shift out at the MSB while quotient bits shift in at the LSB.
  logic [Y_W-1:0]   r_shift;
  logic [1:0]       r_rem;

  logic [2:0]       w_trial;
  logic [2:0]       w_diff;
  logic             w_qbit;
  logic [1:0]       w_rem_nxt;
  logic [Y_W-1:0]   w_shift_nxt;

  // Trial subtract of the divisor from {remainder, next dividend bit}.
  always_comb begin
    w_trial     = {r_rem, r_shift[Y_W-1]};
    w_diff      = w_trial - {1'b0, C0};
    w_qbit      = (w_trial >= {1'b0, C0});
    w_rem_nxt   = 2'b00;
    if (w_qbit) begin
      w_rem_nxt = w_diff[1:0];
    end else begin
      w_rem_nxt = w_trial[1:0];
    end
    w_shift_nxt = {r_shift[Y_W-2:0], w_qbit};
  end

  // The last step's result is presented directly so the caller can capture
  // it on the same edge that produces bit 0.
  assign done     = r_busy && (r_cnt == CNT_LAST);
  assign quotient = w_shift_nxt;
  assign rem      = w_rem_nxt;

  // Divider state: load on start, then one restoring step per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_shift <= '0;
      r_rem   <= 2'b00;
    end else if (start) begin
      r_busy  <= 1'b1;
      r_cnt   <= '0;
      r_shift <= dividend;
      r_rem   <= 2'b00;
    end else if (r_busy) begin
      r_shift <= w_shift_nxt;
      r_rem   <= w_rem_nxt;
      r_cnt   <= r_cnt + CNT_W'(1);
      if (done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fir_deconv.sv
// fir_deconv: inverse of the 3-tap FIR y = 3x[n] + 2x[n-1] + x[n-2].
// Recovers x[n] = (y[n] - 2x[n-1] - x[n-2]) / 3 using a sequential divider,
// with valid/ready handshakes on both sides, and raises a sticky err flag
// for any sample that no FIR-generated stream could produce (negative
// numerator, result above 2^X_W-1, or non-zero remainder).
// Ports:
//   clk, reset - clock and synchronous active-high reset
//   bus        - fir_deconv_if.slave (y_in/y_valid/y_ready, x_out/x_valid/x_ready)
//   err_clr    - clears err (a simultaneous new error wins)
//   err        - sticky error flag
module fir_deconv
  import fir_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  fir_deconv_if.slave  bus,
  input  logic         err_clr,
  output logic         err
);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [X_W-1:0] r_x1;
  logic [X_W-1:0] r_x2;
  logic [X_W-1:0] r_x_out;
  logic           r_neg;
  logic           r_err;

  logic           w_accept;
  logic [Y_W+1:0] w_num;
  logic           w_num_neg;
  logic [Y_W-1:0] w_dividend;
  logic           w_div_done;
  logic [Y_W-1:0] w_quo;
  logic [1:0]     w_rem;
  logic [X_W-1:0] w_x_res;
  logic           w_bad;

  assign w_accept = (r_state == IDLE) && bus.y_valid;

  // Signed numerator in Y_W+2 bits; the top bit is the sign because the
  // subtracted terms never exceed 3*(2^X_W-1).
  always_comb begin
    w_num      = {2'b00, bus.y_in}
               - {{(Y_W+1-X_W){1'b0}}, r_x1, 1'b0}
               - {{(Y_W+2-X_W){1'b0}}, r_x2};
    w_num_neg  = w_num[Y_W+1];
    w_dividend = '0;
    if (w_num_neg) begin
      w_dividend = '0;
    end else begin
      w_dividend = w_num[Y_W-1:0];
    end
  end

  seq_div3 u_div (
    .clk      (clk),
    .reset    (reset),
    .start    (w_accept),
    .dividend (w_dividend),
    .done     (w_div_done),
    .quotient (w_quo),
    .rem      (w_rem)
  );

  // Result shaping: clamp negative to 0, saturate large quotients, and
  // classify the sample as inconsistent with an FIR stream.
  always_comb begin
    w_x_res = '0;
    w_bad   = 1'b0;
    if (r_neg) begin
      w_x_res = '0;
      w_bad   = 1'b1;
    end else if (|w_quo[Y_W-1:X_W]) begin
      w_x_res = '1;
      w_bad   = 1'b1;
    end else begin
      w_x_res = w_quo[X_W-1:0];
      w_bad   = (w_rem != 2'b00);
    end
  end

  // Handshake FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_state_nxt = DIV;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      DIV: begin
        if (w_div_done) begin
          w_state_nxt = OUT;
        end else begin
          w_state_nxt = DIV;
        end
      end
      OUT: begin
        if (bus.x_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = OUT;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, per-sample neg flag, output register and history registers.
  // History takes the emitted (clamped) value so it tracks what the
  // consumer actually saw.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_neg   <= 1'b0;
      r_x_out <= '0;
      r_x1    <= '0;
      r_x2    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_neg <= w_num_neg;
      end
      if (w_div_done) begin
        r_x_out <= w_x_res;
        r_x2    <= r_x1;
        r_x1    <= w_x_res;
      end
    end
  end

  // Sticky error flag; a new error on the same edge overrides err_clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_div_done && w_bad) begin
      r_err <= 1'b1;
    end else if (err_clr) begin
      r_err <= 1'b0;
    end
  end

  // Outputs decode registered state only, so no input reaches them
  // combinationally.
  assign bus.y_ready = (r_state == IDLE);
  assign bus.x_valid = (r_state == OUT);
  assign bus.x_out   = r_x_out;
  assign err         = r_err;

endmodule
